// File: rtl/fir_prog_if.sv
// fir_prog_if: sample, coefficient-write and result signals of the
// programmable FIR filter. The master side is the sample/coefficient source.
// The slave side is the filter.
interface fir_prog_if #(
  parameter int DW     = 8,
  parameter int CW     = 8,
  parameter int OW     = 16,
  parameter int ADDR_W = 4
);
  logic                     in_valid;
  logic signed [DW-1:0]     din;
  logic                     clr;
  logic                     coef_we;
  logic        [ADDR_W-1:0] coef_addr;
  logic signed [CW-1:0]     coef_data;
  logic                     out_valid;
  logic signed [OW-1:0]     dout;
  logic                     ovf;

  modport master (
    output in_valid, din, clr, coef_we, coef_addr, coef_data,
    input  out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din, clr, coef_we, coef_addr, coef_data,
    output out_valid, dout, ovf
  );
endinterface

// File: rtl/fir_prog.sv
// fir_prog: coefficient-programmable transposed-form FIR filter.
// Each accepted sample yields one result on the following clock edge.
// The accumulator is rounded (half up) and arithmetically shifted by SHIFT,
// then reduced to OW bits.
// Optional feature macro FIR_SATURATE_EN: when defined, out-of-range results
// clip to the signed OW limits and raise ovf. When undefined, results wrap and
// ovf is tied low.
// The bus interface instance must be parameterised with the same DW/CW/OW and
// with ADDR_W = $clog2(NTAPS).
module fir_prog #(
  parameter int NTAPS = 13,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input logic       clk,
  input logic       reset,
  fir_prog_if.slave bus
);
  localparam int ADDR_W = $clog2(NTAPS);
  localparam int GW     = $clog2(NTAPS);   // growth bits for the tap sum
  localparam int PW     = DW + CW;         // exact product width
  localparam int AW     = PW + GW;         // accumulator width, cannot overflow

  logic signed [CW-1:0] coef_reg [NTAPS];
  logic signed [AW-1:0] prod     [NTAPS];
  logic signed [AW-1:0] s_reg    [1:NTAPS-1];
  logic signed [AW-1:0] s_next   [1:NTAPS-1];
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] r;
  logic signed [OW-1:0] dout_next;
  logic signed [OW-1:0] dout_reg;
  logic                 out_valid_reg;

  // Coefficient bank. Addresses at or beyond NTAPS match no register, so
  // those writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) coef_reg[k] <= '0;
    end else if (bus.coef_we) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (bus.coef_addr == ADDR_W'(k)) coef_reg[k] <= bus.coef_data;
      end
    end
  end

  // Every tap multiplies the current sample. Products are sign-extended to the
  // full accumulator width before any addition.
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
    logic signed [PW-1:0] mul;
    assign mul      = PW'(coef_reg[gi]) * PW'(bus.din);
    assign prod[gi] = {{GW{mul[PW-1]}}, mul};
  end

  // Transposed chain. Each stage adds its product to the stage behind it.
  // The last stage holds only its product.
  for (genvar gi = 1; gi < NTAPS; gi++) begin : g_sum
    if (gi == NTAPS - 1) begin : g_last
      assign s_next[gi] = prod[gi];
    end else begin : g_mid
      assign s_next[gi] = prod[gi] + s_reg[gi+1];
    end
  end

  // Partial sums advance only on accepted samples.
  // clr flushes them, and clr overrides a same-cycle sample.
  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      for (int k = 1; k < NTAPS; k++) s_reg[k] <= '0;
    end else if (bus.in_valid) begin
      for (int k = 1; k < NTAPS; k++) s_reg[k] <= s_next[k];
    end
  end

  assign acc = prod[0] + s_reg[1];

  // Round half up, then shift arithmetically.
  if (SHIFT > 0) begin : g_round
    localparam logic        [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic signed [AW-1:0] HALF = ONE << (SHIFT - 1);
    logic signed [AW-1:0] acc_rnd;
    assign acc_rnd = acc + HALF;
    assign r       = acc_rnd >>> SHIFT;
  end else begin : g_noround
    assign r = acc;
  end

`ifdef FIR_SATURATE_EN
  logic ovf_next;
  logic ovf_reg;
`endif

  // Reduce the scaled accumulator to the output width.
  if (OW > AW) begin : g_widen
    assign dout_next = {{(OW-AW){r[AW-1]}}, r};
`ifdef FIR_SATURATE_EN
    assign ovf_next = 1'b0;
`endif
  end else if (OW == AW) begin : g_same
    assign dout_next = r;
`ifdef FIR_SATURATE_EN
    assign ovf_next = 1'b0;
`endif
  end else begin : g_narrow
`ifdef FIR_SATURATE_EN
    localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    // Clip to the signed output range and flag the clip.
    always_comb begin
      dout_next = r[OW-1:0];
      ovf_next  = 1'b0;
      if (r > MAXV) begin
        dout_next = MAXV[OW-1:0];
        ovf_next  = 1'b1;
      end else if (r < MINV) begin
        dout_next = MINV[OW-1:0];
        ovf_next  = 1'b1;
      end
    end
`else
    // Wrapping truncation. The discarded high bits go only to a sink.
    logic unused_high;
    assign unused_high = ^r[AW-1:OW];
    assign dout_next   = r[OW-1:0];
`endif
  end

  // Result register. dout/ovf change only on an accepted sample.
  // out_valid pulses one cycle per accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      dout_reg      <= '0;
`ifdef FIR_SATURATE_EN
      ovf_reg       <= 1'b0;
`endif
    end else if (bus.clr) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        dout_reg <= dout_next;
`ifdef FIR_SATURATE_EN
        ovf_reg  <= ovf_next;
`endif
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.dout      = dout_reg;
`ifdef FIR_SATURATE_EN
  assign bus.ovf       = ovf_reg;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_fir_prog.sv
// tb_fir_prog: scoreboard bench for fir_prog.
// It uses three instances: u_main with defaults, u_rnd with SHIFT=2 and
// u_sat with OW=8. Stimulus pushes hand-computed results into per-instance
// queues. A negedge monitor pops an entry on every out_valid and compares
// value, ovf and arrival cycle.
module tb_fir_prog;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

`ifdef FIR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int dout;
    bit ovf;
    int due;
  } exp_t;

  exp_t q_m[$];
  exp_t q_r[$];
  exp_t q_s[$];

  fir_prog_if #(.DW(8), .CW(8), .OW(16), .ADDR_W(4)) if_m ();
  fir_prog_if #(.DW(8), .CW(8), .OW(16), .ADDR_W(4)) if_r ();
  fir_prog_if #(.DW(8), .CW(8), .OW(8),  .ADDR_W(4)) if_s ();

  fir_prog #(.NTAPS(13), .DW(8), .CW(8), .OW(16), .SHIFT(0)) u_main (
    .clk(clk), .reset(reset), .bus(if_m));
  fir_prog #(.NTAPS(13), .DW(8), .CW(8), .OW(16), .SHIFT(2)) u_rnd (
    .clk(clk), .reset(reset), .bus(if_r));
  fir_prog #(.NTAPS(13), .DW(8), .CW(8), .OW(8), .SHIFT(0)) u_sat (
    .clk(clk), .reset(reset), .bus(if_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", nm, got, want);
    end else begin
      $display("ok   %s = %0d", nm, got);
    end
  endtask

  task automatic push(input int id, input int y, input bit o);
    exp_t e;
    e.dout = y;
    e.ovf  = o;
    e.due  = cyc + 1;
    case (id)
      0:       q_m.push_back(e);
      1:       q_r.push_back(e);
      default: q_s.push_back(e);
    endcase
  endtask

  task automatic send(input int id, input int x, input int y, input bit o);
    push(id, y, o);
    case (id)
      0:       begin if_m.in_valid = 1'b1; if_m.din = 8'(x); end
      1:       begin if_r.in_valid = 1'b1; if_r.din = 8'(x); end
      default: begin if_s.in_valid = 1'b1; if_s.din = 8'(x); end
    endcase
    tick();
    if_m.in_valid = 1'b0;
    if_r.in_valid = 1'b0;
    if_s.in_valid = 1'b0;
  endtask

  task automatic wr_coef(input int id, input int addr, input int data);
    case (id)
      0:       begin if_m.coef_we = 1'b1; if_m.coef_addr = 4'(addr); if_m.coef_data = 8'(data); end
      1:       begin if_r.coef_we = 1'b1; if_r.coef_addr = 4'(addr); if_r.coef_data = 8'(data); end
      default: begin if_s.coef_we = 1'b1; if_s.coef_addr = 4'(addr); if_s.coef_data = 8'(data); end
    endcase
    tick();
    if_m.coef_we = 1'b0;
    if_r.coef_we = 1'b0;
    if_s.coef_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mon(input int id, input string nm, input bit v, input int d, input bit o);
    exp_t e;
    bit   empty;
    if (!v) return;
    checks++;
    empty = 1'b0;
    case (id)
      0:       if (q_m.size() == 0) empty = 1'b1; else e = q_m.pop_front();
      1:       if (q_r.size() == 0) empty = 1'b1; else e = q_r.pop_front();
      default: if (q_s.size() == 0) empty = 1'b1; else e = q_s.pop_front();
    endcase
    if (empty) begin
      failures++;
      $display("FAIL %s unexpected out_valid at cyc=%0d dout=%0d required no output", nm, cyc, d);
    end else if (d !== e.dout || o !== e.ovf || cyc !== e.due) begin
      failures++;
      $display("FAIL %s got dout=%0d ovf=%0d cyc=%0d required dout=%0d ovf=%0d cyc=%0d",
               nm, d, o, cyc, e.dout, e.ovf, e.due);
    end else begin
      $display("ok   %s dout=%0d ovf=%0d cyc=%0d", nm, d, o, cyc);
    end
  endtask

  // Monitor: check every presented result against the scoreboard.
  always @(negedge clk) begin
    mon(0, "main", if_m.out_valid, int'(if_m.dout), if_m.ovf);
    mon(1, "rnd",  if_r.out_valid, int'(if_r.dout), if_r.ovf);
    mon(2, "sat",  if_s.out_valid, int'(if_s.dout), if_s.ovf);
  end

  initial begin
    reset = 1'b1;
    if_m.in_valid = 1'b0; if_m.din = '0; if_m.clr = 1'b0;
    if_m.coef_we = 1'b0; if_m.coef_addr = '0; if_m.coef_data = '0;
    if_r.in_valid = 1'b0; if_r.din = '0; if_r.clr = 1'b0;
    if_r.coef_we = 1'b0; if_r.coef_addr = '0; if_r.coef_data = '0;
    if_s.in_valid = 1'b0; if_s.din = '0; if_s.clr = 1'b0;
    if_s.coef_we = 1'b0; if_s.coef_addr = '0; if_s.coef_data = '0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", int'(if_m.out_valid), 0);
    chk("reset_dout", int'(if_m.dout), 0);
    chk("reset_ovf", int'(if_m.ovf), 0);
    tick();

    // Impulse response with h[k]=k+1. Out-of-range addresses must not disturb it.
    for (int k = 0; k < 13; k++) wr_coef(0, k, k + 1);
    wr_coef(0, 13, 100);
    wr_coef(0, 15, -1);
    send(0, 1, 1, 1'b0);
    for (int k = 1; k < 13; k++) send(0, 0, k + 1, 1'b0);
    send(0, 0, 0, 1'b0);

    // Same impulse with three idle cycles between samples.
    send(0, 1, 1, 1'b0);
    for (int k = 1; k < 13; k++) begin
      idle(3);
      send(0, 0, k + 1, 1'b0);
    end
    idle(3);
    send(0, 0, 0, 1'b0);

    // clr after three outputs. Its same-cycle sample (7) is dropped.
    send(0, 1, 1, 1'b0);
    send(0, 0, 2, 1'b0);
    send(0, 0, 3, 1'b0);
    if_m.clr = 1'b1; if_m.in_valid = 1'b1; if_m.din = 8'sd7;
    tick();
    if_m.clr = 1'b0; if_m.in_valid = 1'b0;
    send(0, 1, 1, 1'b0);
    for (int k = 1; k < 13; k++) send(0, 0, k + 1, 1'b0);

    // Coefficient write colliding with a sample: the old h[0]=1 applies first.
    for (int k = 1; k < 13; k++) wr_coef(0, k, 0);
    wr_coef(0, 0, 1);
    push(0, 5, 1'b0);
    if_m.coef_we = 1'b1; if_m.coef_addr = 4'd0; if_m.coef_data = 8'sd2;
    if_m.in_valid = 1'b1; if_m.din = 8'sd5;
    tick();
    if_m.coef_we = 1'b0; if_m.in_valid = 1'b0;
    send(0, 5, 10, 1'b0);

    // Rounding, SHIFT=2: (x+2)>>>2.
    wr_coef(1, 0, 1);
    send(1, 6, 2, 1'b0);
    send(1, -6, -1, 1'b0);
    send(1, 5, 1, 1'b0);
    send(1, 2, 1, 1'b0);
    send(1, -2, 0, 1'b0);
    send(1, -3, -1, 1'b0);
    send(1, 127, 32, 1'b0);
    send(1, -128, -32, 1'b0);

    // OW=8 with h[0]=h[1]=127. The expected values are clipped or wrapped.
    wr_coef(2, 0, 127);
    wr_coef(2, 1, 127);
    send(2, 127,  SAT ? 127 : 1, SAT);
    send(2, 127,  SAT ? 127 : 2, SAT);
    send(2, -128, -127, 1'b0);
    send(2, -128, SAT ? -128 : 0, SAT);
    send(2, 0,    -128, SAT);
    idle(3);
    @(negedge clk);
    chk("sat_hold_dout", int'(if_s.dout), -128);
    chk("sat_hold_ovf", int'(if_s.ovf), SAT ? 1 : 0);
    tick();

    // Reset mid-stream. The sample held high during reset is ignored.
    for (int k = 0; k < 13; k++) wr_coef(0, k, k + 1);
    send(0, 1, 1, 1'b0);
    send(0, 0, 2, 1'b0);
    send(0, 0, 3, 1'b0);
    tick();
    reset = 1'b1; if_m.in_valid = 1'b1; if_m.din = 8'sd1;
    idle(2);
    reset = 1'b0; if_m.in_valid = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", int'(if_m.out_valid), 0);
    chk("midreset_dout", int'(if_m.dout), 0);
    tick();
    send(0, 1, 0, 1'b0);
    for (int k = 0; k < 13; k++) wr_coef(0, k, k + 1);
    send(0, 0, 0, 1'b0);
    send(0, 0, 0, 1'b0);
    send(0, 1, 1, 1'b0);
    send(0, 0, 2, 1'b0);
    idle(4);

    chk("main_queue_left", q_m.size(), 0);
    chk("rnd_queue_left", q_r.size(), 0);
    chk("sat_queue_left", q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_prog.md
# fir_prog

Parametrised, coefficient-programmable transposed-form FIR filter with sample-valid handshake, rounding output scaler and optional saturation. It sits in the sample datapath between a signed sample source and downstream DSP. Coefficients are loaded at run time through a register-style write port. The filter does not need to be re-synthesised to change its taps.

## Interface
- NTAPS, 13: number of taps, 2..64
- DW, 8: input sample width, signed
- CW, 8: coefficient width, signed
- OW, 16: output width, signed
- SHIFT, 0: arithmetic right shift applied to the accumulator before output, 0..(DW+CW-1)
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  din holds a new sample this cycle
- din  in  DW  signed input sample
- clr  in  1  synchronous flush of the delay line; coefficients are kept
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  tap index k for h[k]
- coef_data  in  CW  signed coefficient value
- out_valid  out  1  dout holds a new result; one-cycle pulse
- dout  out  OW  signed filtered output
- ovf  out  1  result was clipped; valid only with out_valid

## Operation
- Function: y[n] = sum over k=0..NTAPS-1 of h[k]·x[n-k], where x[n] is the n-th accepted sample.
- Accumulator width: AW = DW+CW+clog2(NTAPS). All products and partial sums are sign-extended to AW, so no internal overflow can occur.
- Transposed delay line: partial sums s[1..NTAPS-1], each AW bits wide. On an in_valid cycle:
  - s[k] <= h[k]·din + s[k+1] for k = 1..NTAPS-2
  - s[NTAPS-1] <= h[NTAPS-1]·din
  - acc = h[0]·din + s[1]
- Stall behaviour: when in_valid=0, s[] holds. Gaps between samples do not change results.
- Output scaler:
  - If SHIFT>0, r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up). If SHIFT=0, r = acc.
  - r is then reduced to OW bits according to the Configuration section.
- Coefficient bank:
  - NTAPS registers of CW bits.
  - coef_we writes h[coef_addr].
  - Writes with coef_addr ≥ NTAPS are ignored.
- clr: zeroes s[] and out_valid at the next edge. A sample presented in the same cycle as clr is dropped.
- Priority, highest first: reset, clr, in_valid.
- Reset values: s[]=0, h[]=0, dout=0, out_valid=0, ovf=0.

## Timing
- Latency: a sample accepted at edge t produces out_valid=1 and dout=y[n] at edge t+1 (one cycle).
- Throughput: one sample per cycle. Back-to-back in_valid is supported.
- out_valid is high exactly one cycle per accepted sample.
- dout and ovf hold their last value while out_valid=0.
- Simultaneous coef_we and in_valid: the sample in that cycle uses the old coefficient. The new value applies from the next accepted sample. Partial sums already in s[] keep their old-coefficient contributions, which is the expected transient.
- Reset asserted mid-stream: all state, including coefficients, clears at that edge. An in_valid that is high during reset is ignored. The first output after reset is deasserted comes from the first sample accepted after it.

## Configuration
- FIR_SATURATE_EN defined:
  - If r exceeds the signed OW range, dout clips to 2^(OW-1)-1 or -2^(OW-1) and ovf=1 with that out_valid.
  - Otherwise ovf=0.
- FIR_SATURATE_EN undefined:
  - dout = r[OW-1:0], which wraps on overflow.
  - ovf is tied to 0.
  - No comparison logic is built.

## Test plan
- Impulse response. Defaults; load h[k]=k+1 for k=0..12; send din=1 then twelve 0s with in_valid every cycle. Required: dout = 1,2,…,13 on consecutive out_valid pulses, then 0.
- Stalled stream. Same coefficients and impulse, but with in_valid=0 for 3 cycles between samples. Required: the same dout sequence 1..13, with out_valid only one cycle after each accepted sample.
- Coefficient write collision. h[0]=1 with all other taps 0. In the same cycle, write h[0]=2 and send din=5, then send din=5 again. Required: outputs 5 then 10.
- Rounding. SHIFT=2, h[0]=1, din=6. Required: dout=2, since (6+2)>>>2 = 2.
- Saturation with OW=8 and FIR_SATURATE_EN defined. Set h[0]=h[1]=127, then send din=127,127.
  - Required second output: 127 with ovf=1.
  - With the macro undefined, the second output is the low 8 bits of 32258, i.e. 2, with ovf=0.
- Reset and clr mid-stream.
  - Assert clr after 3 impulse-response outputs, then send one impulse. Required: the sequence restarts at 1 with no residue.
  - Assert reset mid-stream. Required: out_valid=0, dout=0, and all h[] read back as 0 (din=1 yields output 0).
